// File: rtl/edit_ctrl.sv
// rtl/edit_ctrl.sv - front-panel edit controller: button conditioning, edit FSM, adjust pulses
//
// Purpose: synchronises and debounces the mode/up/down push-buttons, steps the
// RUN -> EDIT_HH -> EDIT_MM -> EDIT_SS -> RUN edit cycle, and drives the time
// counter's freeze/sel/inc/dec inputs plus a field blink flag for the display.
// Optional feature macro: EDIT_AUTOREPEAT_EN (hold-to-repeat on up/down).
//
// Ports:
//   clk               system clock
//   rst               synchronous active-high reset
//   tick1Hz           one-cycle 1 Hz strobe
//   btn_mode          raw mode button, asynchronous, active-high
//   btn_up, btn_down  raw adjust buttons, asynchronous, active-high
//   freeze            high in any edit state
//   sel               field select: 00 none, 01 ss, 10 mm, 11 hh
//   inc, dec          one-cycle adjust pulses
//   blink             blink phase of the selected field, 0 in RUN
module edit_ctrl #(
  parameter int DB_CYCLES     = 500000,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 10000000,
  parameter int TIMEOUT_S     = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick1Hz,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic       freeze,
  output logic [1:0] sel,
  output logic       inc,
  output logic       dec,
  output logic       blink
);

  localparam int DBW = $clog2(DB_CYCLES + 1);
  localparam int TOW = $clog2(TIMEOUT_S + 1);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);
  localparam logic [TOW-1:0] TO_LAST = TOW'(TIMEOUT_S - 1);

  // Button bit positions inside the packed button vectors.
  localparam int BM = 0;
  localparam int BU = 1;
  localparam int BD = 2;

  // Encoding matches the sel field code so sel is the state register itself.
  typedef enum logic [1:0] {
    RUN     = 2'b00,
    EDIT_SS = 2'b01,
    EDIT_MM = 2'b10,
    EDIT_HH = 2'b11
  } state_e;

  logic [2:0]     raw;
  logic [2:0]     sync1_q, sync2_q;
  logic [2:0]     db_q, db_d, db_prev_q;
  logic [DBW-1:0] db_cnt_q [3];
  logic [DBW-1:0] db_cnt_d [3];
  logic [2:0]     press;
  logic           both_held;
  state_e         state_q, state_d;
  logic           freeze_q, freeze_d;
  logic           inc_q, inc_d;
  logic           dec_q, dec_d;
  logic           blink_q, blink_d;
  logic [TOW-1:0] idle_q, idle_d;

`ifdef EDIT_AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW      = $clog2(RPT_MAX + 1);
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

  logic          rpt_on_q, rpt_on_d;
  logic          rpt_dn_q, rpt_dn_d;
  logic          rpt_first_q, rpt_first_d;
  logic [RW-1:0] rpt_cnt_q, rpt_cnt_d;
  logic          rpt_level;
`else
  logic unused_repeat_params;
  assign unused_repeat_params = (REPEAT_DELAY > 0) ^ (REPEAT_PERIOD > 0);
`endif

  assign raw       = {btn_down, btn_up, btn_mode};
  assign press     = db_q & ~db_prev_q;
  assign both_held = db_q[BU] & db_q[BD];

  // Debounce: db follows the synchronised level only after DB_CYCLES
  // consecutive disagreeing cycles; any agreeing cycle restarts the count.
  always_comb begin
    db_d = db_q;
    for (int i = 0; i < 3; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          db_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idle_d  = idle_q;
    blink_d = blink_q;
    inc_d   = 1'b0;
    dec_d   = 1'b0;
`ifdef EDIT_AUTOREPEAT_EN
    rpt_on_d    = rpt_on_q;
    rpt_dn_d    = rpt_dn_q;
    rpt_first_d = rpt_first_q;
    rpt_cnt_d   = rpt_cnt_q;
    rpt_level   = rpt_dn_q ? db_q[BD] : db_q[BU];
`endif
    if (state_q == RUN) begin
      idle_d  = '0;
      blink_d = 1'b0;
`ifdef EDIT_AUTOREPEAT_EN
      rpt_on_d  = 1'b0;
      rpt_cnt_d = '0;
`endif
      if (press[BM]) begin
        state_d = EDIT_HH;
        blink_d = 1'b1;
      end
    end else if (press[BM]) begin
      // Mode wins over a simultaneous adjust press or timeout.
      case (state_q)
        EDIT_HH: state_d = EDIT_MM;
        EDIT_MM: state_d = EDIT_SS;
        default: state_d = RUN;
      endcase
      idle_d  = '0;
      blink_d = (state_d != RUN);
`ifdef EDIT_AUTOREPEAT_EN
      rpt_on_d  = 1'b0;
      rpt_cnt_d = '0;
`endif
    end else if (tick1Hz && !(press[BU] | press[BD]) && (idle_q == TO_LAST)) begin
      state_d = RUN;
      idle_d  = '0;
      blink_d = 1'b0;
`ifdef EDIT_AUTOREPEAT_EN
      rpt_on_d  = 1'b0;
      rpt_cnt_d = '0;
`endif
    end else begin
      if (press[BU] | press[BD]) begin
        idle_d = '0;
      end else if (tick1Hz) begin
        idle_d = idle_q + 1'b1;
      end
      if (tick1Hz) begin
        blink_d = ~blink_q;
      end
      if (!both_held) begin
        inc_d = press[BU];
        dec_d = press[BD];
      end
`ifdef EDIT_AUTOREPEAT_EN
      // Repeat arms only on a fresh single-button press; chord or release cancels it.
      if (both_held) begin
        rpt_on_d  = 1'b0;
        rpt_cnt_d = '0;
      end else if (press[BU] | press[BD]) begin
        rpt_on_d    = 1'b1;
        rpt_dn_d    = press[BD];
        rpt_first_d = 1'b1;
        rpt_cnt_d   = '0;
      end else if (rpt_on_q) begin
        if (!rpt_level) begin
          rpt_on_d  = 1'b0;
          rpt_cnt_d = '0;
        end else if (rpt_cnt_q == (rpt_first_q ? DELAY_LAST : PERIOD_LAST)) begin
          rpt_cnt_d   = '0;
          rpt_first_d = 1'b0;
          inc_d       = ~rpt_dn_q;
          dec_d       = rpt_dn_q;
        end else begin
          rpt_cnt_d = rpt_cnt_q + 1'b1;
        end
      end
`endif
    end
    freeze_d = (state_d != RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      db_q      <= '0;
      db_prev_q <= '0;
      for (int i = 0; i < 3; i++) begin
        db_cnt_q[i] <= '0;
      end
      state_q  <= RUN;
      freeze_q <= 1'b0;
      inc_q    <= 1'b0;
      dec_q    <= 1'b0;
      blink_q  <= 1'b0;
      idle_q   <= '0;
`ifdef EDIT_AUTOREPEAT_EN
      rpt_on_q    <= 1'b0;
      rpt_dn_q    <= 1'b0;
      rpt_first_q <= 1'b0;
      rpt_cnt_q   <= '0;
`endif
    end else begin
      sync1_q   <= raw;
      sync2_q   <= sync1_q;
      db_q      <= db_d;
      db_prev_q <= db_q;
      for (int i = 0; i < 3; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
      state_q  <= state_d;
      freeze_q <= freeze_d;
      inc_q    <= inc_d;
      dec_q    <= dec_d;
      blink_q  <= blink_d;
      idle_q   <= idle_d;
`ifdef EDIT_AUTOREPEAT_EN
      rpt_on_q    <= rpt_on_d;
      rpt_dn_q    <= rpt_dn_d;
      rpt_first_q <= rpt_first_d;
      rpt_cnt_q   <= rpt_cnt_d;
`endif
    end
  end

  assign freeze = freeze_q;
  assign sel    = state_q;
  assign inc    = inc_q;
  assign dec    = dec_q;
  assign blink  = blink_q;

endmodule

// File: tb/tb_edit_ctrl.sv
// tb/tb_edit_ctrl.sv - self-checking bench for edit_ctrl
module tb_edit_ctrl;

  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RP = 5;
  localparam int TO = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick1Hz;
  logic       btn_mode, btn_up, btn_down;
  logic       freeze;
  logic [1:0] sel;
  logic       inc, dec, blink;

  int errors = 0;
  int checks = 0;

  edit_ctrl #(
    .DB_CYCLES    (DB),
    .REPEAT_DELAY (RD),
    .REPEAT_PERIOD(RP),
    .TIMEOUT_S    (TO)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .tick1Hz (tick1Hz),
    .btn_mode(btn_mode),
    .btn_up  (btn_up),
    .btn_down(btn_down),
    .freeze  (freeze),
    .sel     (sel),
    .inc     (inc),
    .dec     (dec),
    .blink   (blink)
  );

  always #5 clk = ~clk;

  // Behavioural model: raw sample history per edge, debounce judged over a
  // window of that history, repeat pulses scheduled by absolute edge number.
  bit [2:0]   hist [0:8191];
  int         e = 0;
  bit         started = 0;
  logic [1:0] m_sel;
  bit         m_inc, m_dec, m_blink;
  int         m_idle, rep_held, rep_due;
  bit [2:0]   m_db, m_db_old, m_press, m_nd;
  bit         m_both, m_ok;
  int         m_inc_cnt = 0;
  int         m_dec_cnt = 0;

  always @(posedge clk) begin
    hist[e & 8191] = {btn_down, btn_up, btn_mode};
    if (rst) begin
      hist[e & 8191] = 3'b000;
      hist[(e + 8191) & 8191] = 3'b000;
      m_db = 0; m_db_old = 0; m_sel = 2'b00;
      m_inc = 0; m_dec = 0; m_blink = 0; m_idle = 0; rep_held = 0;
      started = 1;
    end else begin
      m_press = m_db & ~m_db_old;
      m_both  = m_db[1] && m_db[2];
      m_nd    = m_db;
      if (e >= DB + 1) begin
        for (int b = 0; b < 3; b++) begin
          m_ok = 1;
          for (int k = e - 1 - DB; k <= e - 2; k++)
            if (hist[k & 8191][b] == m_db[b]) m_ok = 0;
          if (m_ok) m_nd[b] = ~m_db[b];
        end
      end
      m_inc = 0; m_dec = 0;
      if (m_sel == 2'b00) begin
        m_idle = 0; m_blink = 0; rep_held = 0;
        if (m_press[0]) begin m_sel = 2'b11; m_blink = 1; end
      end else if (m_press[0]) begin
        m_sel = m_sel - 2'd1; m_blink = (m_sel != 2'b00); m_idle = 0; rep_held = 0;
      end else if (m_press[2:1] == 2'b00 && tick1Hz && m_idle + 1 >= TO) begin
        m_sel = 2'b00; m_blink = 0; m_idle = 0; rep_held = 0;
      end else begin
        if (m_press[2:1] != 2'b00) m_idle = 0;
        else if (tick1Hz) m_idle++;
        if (tick1Hz) m_blink = !m_blink;
        if (m_both) rep_held = 0;
        else if (m_press[1] || m_press[2]) begin
          if (m_press[1]) m_inc = 1; else m_dec = 1;
          rep_held = m_press[1] ? 1 : 2;
          rep_due  = e + RD;
        end
`ifdef EDIT_AUTOREPEAT_EN
        else if (rep_held != 0) begin
          if (!m_db[rep_held]) rep_held = 0;
          else if (e == rep_due) begin
            if (rep_held == 1) m_inc = 1; else m_dec = 1;
            rep_due = e + RP;
          end
        end
`endif
      end
      if (m_inc) m_inc_cnt++;
      if (m_dec) m_dec_cnt++;
      m_db_old = m_db;
      m_db     = m_nd;
    end
    e++;
  end

  logic [5:0] got_v, exp_v;
  always @(negedge clk) begin
    if (started) begin
      got_v = {freeze, sel, inc, dec, blink};
      exp_v = {m_sel != 2'b00, m_sel, m_inc, m_dec, m_blink};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL model edge=%0d got {frz,sel,inc,dec,blk}=%b exp=%b", e - 1, got_v, exp_v);
      end
      checks++;
      if ((inc && dec) || ((inc || dec) && !freeze)) begin
        errors++;
        $display("FAIL pulse_guard edge=%0d inc=%b dec=%b freeze=%b exp no overlap, none unfrozen", e - 1, inc, dec, freeze);
      end
    end
  end

  // DUT pulse counters, sampled before the edge updates the outputs.
  int inc_seen = 0;
  int dec_seen = 0;
  always @(posedge clk) begin
    if (inc === 1'b1) inc_seen++;
    if (dec === 1'b1) dec_seen++;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_mode();
    btn_mode = 1'b1; cyc(10);
    btn_mode = 1'b0; cyc(10);
  endtask

  task automatic tick();
    tick1Hz = 1'b1; cyc(1);
    tick1Hz = 1'b0;
  endtask

  function automatic bit rep_hit(input int k);
`ifdef EDIT_AUTOREPEAT_EN
    return (k == 7) || (k == 27) || (k == 32) || (k == 37) || (k == 42);
`else
    return (k == 7);
`endif
  endfunction

  logic [1:0] exp_sel   [4] = '{2'b11, 2'b10, 2'b01, 2'b00};
  logic       exp_frz   [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
  logic       exp_blink [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
  logic [1:0] prev_sel;
  int         i0, d0, md0;

  initial begin
    rst = 1'b1; tick1Hz = 1'b0;
    btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    cyc(3);
    chk("rst_freeze", freeze, 0);
    chk("rst_sel", sel, 0);
    chk("rst_inc", inc, 0);
    chk("rst_dec", dec, 0);
    chk("rst_blink", blink, 0);
    rst = 1'b0;
    cyc(10);

    // 1: mode cycling, response 6 edges after raw rise
    prev_sel = 2'b00;
    for (int p = 0; p < 4; p++) begin
      btn_mode = 1'b1;
      cyc(6);
      chk("mode_early_sel", sel, prev_sel);
      cyc(1);
      chk("mode_sel", sel, exp_sel[p]);
      chk("mode_freeze", freeze, exp_frz[p]);
      chk("mode_blink", blink, exp_blink[p]);
      prev_sel = exp_sel[p];
      cyc(3);
      btn_mode = 1'b0;
      cyc(10);
    end

    // 2: bounce rejection in EDIT_MM
    press_mode(); press_mode();
    chk("t2_sel_mm", sel, 2'b10);
    i0 = inc_seen;
    btn_up = 1'b1; cyc(3);
    btn_up = 1'b0; cyc(1);
    for (int b = 0; b < 12; b++) begin
      btn_up = (b % 2 == 0); cyc(1);
    end
    btn_up = 1'b1;
    cyc(6); chk("t2_inc_early", inc, 0);
    cyc(1); chk("t2_inc_pulse", inc, 1);
    cyc(1); chk("t2_inc_width", inc, 0);
    btn_up = 1'b0;
    cyc(12);
    chk("t2_inc_count", inc_seen - i0, 1);

    // 3: hold-to-repeat in EDIT_HH
    press_mode(); press_mode(); press_mode();
    chk("t3_sel_hh", sel, 2'b11);
    d0 = dec_seen; md0 = m_dec_cnt;
    btn_down = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      cyc(1);
      if (k == 40) btn_down = 1'b0;
      chk($sformatf("t3_dec_k%0d", k), dec, rep_hit(k));
    end
`ifdef EDIT_AUTOREPEAT_EN
    chk("t3_dut_dec_count", dec_seen - d0, 5);
    chk("t3_model_dec_count", m_dec_cnt - md0, 5);
`else
    chk("t3_dut_dec_count", dec_seen - d0, 1);
    chk("t3_model_dec_count", m_dec_cnt - md0, 1);
`endif

    // 4: timeout in EDIT_SS, then restart of the idle count by a press
    press_mode(); press_mode();
    chk("t4_sel_ss", sel, 2'b01);
    tick(); chk("t4_blink_t1", blink, 0); cyc(4);
    tick(); chk("t4_blink_t2", blink, 1); chk("t4_sel_t2", sel, 2'b01); cyc(4);
    tick(); chk("t4_timeout_sel", sel, 2'b00); chk("t4_timeout_freeze", freeze, 0);
    cyc(4);
    press_mode();
    tick(); cyc(3); tick(); cyc(3);
    btn_up = 1'b1; cyc(8);
    btn_up = 1'b0; cyc(12);
    tick(); cyc(3); tick(); cyc(3);
    chk("t4_restart_sel", sel, 2'b11);
    tick();
    chk("t4_restart_timeout", sel, 2'b00);
    cyc(4);

    // 5: chord suppression in EDIT_MM
    press_mode(); press_mode();
    chk("t5_sel_mm", sel, 2'b10);
    i0 = inc_seen; d0 = dec_seen;
    btn_up = 1'b1; btn_down = 1'b1; cyc(30);
    chk("t5_chord_inc", inc_seen - i0, 0);
    chk("t5_chord_dec", dec_seen - d0, 0);
    btn_down = 1'b0; cyc(30);
    chk("t5_release_inc", inc_seen - i0, 0);
    btn_up = 1'b0; cyc(10);
    btn_up = 1'b1; cyc(8);
    btn_up = 1'b0; cyc(12);
    chk("t5_fresh_inc", inc_seen - i0, 1);

    // 6: reset mid-repeat in EDIT_HH
    press_mode(); press_mode(); press_mode();
    chk("t6_sel_hh", sel, 2'b11);
    btn_down = 1'b1; cyc(30);
    rst = 1'b1; cyc(1);
    chk("t6_freeze", freeze, 0);
    chk("t6_sel", sel, 0);
    chk("t6_inc", inc, 0);
    chk("t6_dec", dec, 0);
    rst = 1'b0;
    d0 = dec_seen;
    cyc(40);
    chk("t6_no_dec", dec_seen - d0, 0);
    chk("t6_still_run", sel, 0);
    btn_down = 1'b0; cyc(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
